program_loader: RTL and testbench
=================================

# program_loader

Boot-time controller between the machine-code word source and the instruction memory. It captures the 16-bit word stream (`src_valid`/`src_data`) into a small FIFO and writes the words to consecutive memory addresses from 0. The memory side is throttled by `mem_ready`. When the stream ends and every word is written, it releases the processor core from reset.

## Interface
- `AW`, 8: instruction-memory address width; capacity 2^AW words.
- `FIFO_DEPTH`, 4: capture FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `src_valid`  in  1  source word present this cycle; source has no backpressure.
- `src_data`  in  16  machine-code word.
- `mem_ready`  in  1  memory accepts a write this cycle.
- `mem_we`  out  1  write request.
- `mem_addr`  out  AW  write address.
- `mem_wdata`  out  16  write data.
- `cpu_rst_b`  out  1  core reset; low until load completes.
- `done`  out  1  load complete, sticky.
- `error`  out  1  overflow detected, sticky.
- `word_count`  out  AW+1  words written to memory.
- `checksum`  out  16  running sum of written words (see Configuration).

## Operation
- Reset values:
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0 (FIFO head, empty).
  - `cpu_rst_b`=0, `done`=0, `error`=0.
  - `word_count`=0, `checksum`=0.
  - FIFO is empty; state is IDLE.
- States: IDLE, LOAD, DRAIN, DONE, ERROR.
- IDLE → LOAD on the first cycle with `src_valid`=1. That word is pushed.
- LOAD:
  - Each `src_valid`=1 cycle pushes `src_data`.
  - The first cycle with `src_valid`=0 → DRAIN; end of stream.
- DRAIN: no pushes; `src_valid` is ignored. → DONE when the FIFO is empty and no write is pending.
- Write side (LOAD, DRAIN):
  - `mem_we` = FIFO not empty, combinational.
  - `mem_wdata` = FIFO head.
  - `mem_addr` = `word_count[AW-1:0]`.
  - A write commits when `mem_we`=1 and `mem_ready`=1. The commit pops the FIFO and increments `word_count`.
- Full FIFO:
  - A push with a simultaneous pop is accepted.
  - A push into a full FIFO without a pop → ERROR; the word is dropped.
- Address space:
  - If `word_count` = 2^AW and the FIFO is not empty → ERROR.
  - `word_count` never wraps; `mem_addr` is not written past 2^AW−1.
- DONE:
  - `done`=1 and `cpu_rst_b`=1; both registered.
  - `mem_we`=0; the block holds until `rst_b`.
  - Later `src_valid` is ignored.
- ERROR:
  - `error`=1, `mem_we`=0, `cpu_rst_b` stays 0.
  - Holds until `rst_b`.
- Overflow checks also run in IDLE on the first push. They cannot fail there.
- Reset mid-load:
  - Everything returns to reset values asynchronously.
  - FIFO contents are discarded; the load restarts from address 0.

## Timing
- Push at edge N → earliest `mem_we`=1 in cycle N+1. Memory latency is 1 cycle with `mem_ready` held high.
- Throughput: one word per cycle with `mem_ready`=1. The FIFO absorbs up to FIFO_DEPTH cycles of `mem_ready`=0.
- `src_valid` falls at cycle N → state is DRAIN from edge N. The last commit at edge M → DONE (`done`, `cpu_rst_b` high) from edge M+1.
- `error` rises on the edge that detects the overflow.
- `done` and `error` are never both 1.

## Configuration
- Macro: `PROGRAM_LOADER_CHECKSUM_EN`.
- Defined:
  - `checksum` accumulates `checksum + mem_wdata` (mod 2^16) on each commit.
  - It is frozen in DONE/ERROR and cleared by reset.
- Undefined: no accumulator is built; `checksum` is tied to 16'h0000.

## Test plan
- Stream 3 words 16'h1111, 16'h2222, 16'h3333 with `mem_ready`=1:
  - writes go to addr 0, 1, 2;
  - `word_count`=3;
  - `done`=`cpu_rst_b`=1 two edges after `src_valid` falls;
  - `checksum`=16'h6666 with the macro defined, 0 without it.
- Stream 6 words with `mem_ready`=0 for words 2–5 (FIFO_DEPTH=4, no pops): `error`=1 on the 5th push, `cpu_rst_b`=0, `mem_we`=0 thereafter.
- Same 6 words with `mem_ready` toggling 1/0 each cycle:
  - no error;
  - all 6 words land at addr 0–5 in order;
  - `done`=1.
- AW=2, stream 5 words: 4 words written to addr 0–3, then `error`=1; `word_count`=4.
- Assert `rst_b`=0 after 2 of 4 words written, release, stream 16'hAAAA:
  - outputs reset immediately;
  - the new word is written at addr 0;
  - `word_count`=1, `done`=1.
- After DONE, pulse `src_valid` with 16'hFFFF: no `mem_we`; `word_count` and `checksum` are unchanged.

Source files
------------

// File: rtl/program_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// program_loader_if : word-source and instruction-memory write bus
// Revision : 1.0
// ============================================================================
interface program_loader_if #(
    parameter int AW = 8
);
    logic          src_valid;
    logic [15:0]   src_data;
    logic          mem_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;

    modport master (
        input  src_valid, src_data, mem_ready,
        output mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output src_valid, src_data, mem_ready,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// program_loader : captures a boot word stream into a FIFO, writes it to
//                  instruction memory from address 0, then releases the core.
// Option         : PROGRAM_LOADER_CHECKSUM_EN builds the commit checksum.
// Revision       : 1.0
// ============================================================================
module program_loader #(
    parameter int AW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_b,
    program_loader_if.master   bus,
    output logic               cpu_rst_b,
    output logic               done,
    output logic               error,
    output logic [AW:0]        word_count,
    output logic [15:0]        checksum
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FIFO_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ADDR_END  = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   fifo_mem_q [FIFO_DEPTH];
    logic [15:0]   fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          cpu_rst_b_q, cpu_rst_b_d;

    logic fifo_empty;
    logic fifo_full;
    logic addr_full;
    logic write_active;
    logic mem_we;
    logic commit;
    logic push_req;
    logic push;
    logic overflow;

    always_comb begin
        fifo_empty   = (count_q == '0);
        fifo_full    = (count_q == FIFO_FULL);
        addr_full    = (word_count_q == ADDR_END);
        write_active = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
        // Never present a write once the address space is exhausted.
        mem_we       = write_active && !fifo_empty && !addr_full;
        commit       = mem_we && bus.mem_ready;
        push_req     = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && bus.src_valid;
        // A push into a full FIFO is only legal when a pop frees a slot this cycle.
        overflow     = (push_req && fifo_full && !commit) || (addr_full && !fifo_empty);
        push         = push_req && !overflow;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (overflow)
                    state_d = ST_ERROR;
                else if (bus.src_valid)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (overflow)
                    state_d = ST_ERROR;
                else if (!bus.src_valid)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (overflow)
                    state_d = ST_ERROR;
                else if (fifo_empty)
                    state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + (PW+1)'(push) - (PW+1)'(commit);
        word_count_d = word_count_q + (AW+1)'(commit);
        if (push) begin
            fifo_mem_d[wr_ptr_q] = bus.src_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (commit)
            rd_ptr_d = rd_ptr_q + PW'(1);
        done_d      = (state_d == ST_DONE);
        cpu_rst_b_d = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_mem_q[i] <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            word_count_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_rst_b_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fifo_mem_q   <= fifo_mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            word_count_q <= word_count_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_rst_b_q  <= cpu_rst_b_d;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    // Only commits add in, so the sum is naturally frozen in DONE and ERROR.
    always_comb begin
        checksum_d = checksum_q;
        if (commit)
            checksum_d = checksum_q + fifo_mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            checksum_q <= '0;
        else
            checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = word_count_q[AW-1:0];
    assign bus.mem_wdata = fifo_mem_q[rd_ptr_q];
    assign cpu_rst_b     = cpu_rst_b_q;
    assign done          = done_q;
    assign error         = error_q;
    assign word_count    = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for program_loader: an AW=8 instance for the main scenarios
// and an AW=2 instance for address-space exhaustion.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    program_loader_if #(.AW(8)) bus_a ();
    program_loader_if #(.AW(2)) bus_b ();

    logic        a_cpu_rst_b, a_done, a_error;
    logic [8:0]  a_word_count;
    logic [15:0] a_checksum;
    logic        b_cpu_rst_b, b_done, b_error;
    logic [2:0]  b_word_count;
    logic [15:0] b_checksum;

    program_loader #(.AW(8), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_b(rst_b), .bus(bus_a),
        .cpu_rst_b(a_cpu_rst_b), .done(a_done), .error(a_error),
        .word_count(a_word_count), .checksum(a_checksum)
    );

    program_loader #(.AW(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_b(rst_b), .bus(bus_b),
        .cpu_rst_b(b_cpu_rst_b), .done(b_done), .error(b_error),
        .word_count(b_word_count), .checksum(b_checksum)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]  log_a_addr [$];
    logic [15:0] log_a_data [$];
    logic [1:0]  log_b_addr [$];
    logic [15:0] log_b_data [$];

    // Inputs change 1ns after the rising edge, so the falling edge sees the
    // exact values the next rising edge will commit on.
    always @(negedge clk) begin
        if (rst_b && bus_a.mem_we && bus_a.mem_ready) begin
            log_a_addr.push_back(bus_a.mem_addr);
            log_a_data.push_back(bus_a.mem_wdata);
        end
        if (rst_b && bus_b.mem_we && bus_b.mem_ready) begin
            log_b_addr.push_back(bus_b.mem_addr);
            log_b_data.push_back(bus_b.mem_wdata);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus_a.src_valid = 1'b0; bus_a.src_data = '0; bus_a.mem_ready = 1'b0;
        bus_b.src_valid = 1'b0; bus_b.src_data = '0; bus_b.mem_ready = 1'b0;
    endtask

    task automatic do_reset;
        rst_b = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst_b = 1'b1;
        tick();
        log_a_addr.delete(); log_a_data.delete();
        log_b_addr.delete(); log_b_data.delete();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_b = 1'b0;
        #2;
        n_chk++; if (bus_a.mem_we !== 1'b0) $display("FAIL reset mem_we: got %0h want 0", bus_a.mem_we); else n_pass++;
        n_chk++; if (bus_a.mem_addr !== 8'h00) $display("FAIL reset mem_addr: got %0h want 0", bus_a.mem_addr); else n_pass++;
        n_chk++; if (bus_a.mem_wdata !== 16'h0000) $display("FAIL reset mem_wdata: got %0h want 0", bus_a.mem_wdata); else n_pass++;
        n_chk++; if (a_cpu_rst_b !== 1'b0) $display("FAIL reset cpu_rst_b: got %0h want 0", a_cpu_rst_b); else n_pass++;
        n_chk++; if (a_done !== 1'b0) $display("FAIL reset done: got %0h want 0", a_done); else n_pass++;
        n_chk++; if (a_error !== 1'b0) $display("FAIL reset error: got %0h want 0", a_error); else n_pass++;
        n_chk++; if (a_word_count !== 9'd0) $display("FAIL reset word_count: got %0d want 0", a_word_count); else n_pass++;
        n_chk++; if (a_checksum !== 16'h0000) $display("FAIL reset checksum: got %0h want 0", a_checksum); else n_pass++;
        n_chk++; if (b_word_count !== 3'd0) $display("FAIL reset b word_count: got %0d want 0", b_word_count); else n_pass++;
        do_reset();
    endtask

    task automatic test_stream3;
        logic [15:0] w [3] = '{16'h1111, 16'h2222, 16'h3333};
        logic [15:0] exp_sum;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        exp_sum = 16'h6666;
`else
        exp_sum = 16'h0000;
`endif
        do_reset();
        bus_a.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_a.src_valid = 1'b1; bus_a.src_data = w[i];
            tick();
        end
        bus_a.src_valid = 1'b0;
        tick();
        n_chk++; if (a_done !== 1'b0) $display("FAIL stream3 done early: got %0h want 0", a_done); else n_pass++;
        tick();
        n_chk++; if (a_done !== 1'b1) $display("FAIL stream3 done: got %0h want 1", a_done); else n_pass++;
        n_chk++; if (a_cpu_rst_b !== 1'b1) $display("FAIL stream3 cpu_rst_b: got %0h want 1", a_cpu_rst_b); else n_pass++;
        n_chk++; if (a_word_count !== 9'd3) $display("FAIL stream3 word_count: got %0d want 3", a_word_count); else n_pass++;
        n_chk++; if (a_checksum !== exp_sum) $display("FAIL stream3 checksum: got %0h want %0h", a_checksum, exp_sum); else n_pass++;
        n_chk++; if (log_a_addr.size() !== 3) $display("FAIL stream3 writes: got %0d want 3", log_a_addr.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            logic [7:0]  ga;
            logic [15:0] gd;
            ga = (i < log_a_addr.size()) ? log_a_addr[i] : 8'hxx;
            gd = (i < log_a_data.size()) ? log_a_data[i] : 16'hxxxx;
            n_chk++; if (ga !== 8'(i) || gd !== w[i])
                $display("FAIL stream3 write%0d: got %0h@%0h want %0h@%0h", i, gd, ga, w[i], i);
            else n_pass++;
        end
    endtask

    task automatic test_fifo_overflow;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus_a.src_valid = 1'b1; bus_a.src_data = 16'h0100 + 16'(i);
            bus_a.mem_ready = (i == 0);
            tick();
        end
        n_chk++; if (a_error !== 1'b0) $display("FAIL ovf error after 4th push: got %0h want 0", a_error); else n_pass++;
        bus_a.src_data = 16'h0104; bus_a.mem_ready = 1'b0;
        tick();
        n_chk++; if (a_error !== 1'b1) $display("FAIL ovf error on 5th push: got %0h want 1", a_error); else n_pass++;
        n_chk++; if (a_cpu_rst_b !== 1'b0) $display("FAIL ovf cpu_rst_b: got %0h want 0", a_cpu_rst_b); else n_pass++;
        n_chk++; if (bus_a.mem_we !== 1'b0) $display("FAIL ovf mem_we: got %0h want 0", bus_a.mem_we); else n_pass++;
        bus_a.src_data = 16'h0105; bus_a.mem_ready = 1'b1;
        tick();
        bus_a.src_valid = 1'b0;
        n_chk++; if (bus_a.mem_we !== 1'b0) $display("FAIL ovf mem_we later: got %0h want 0", bus_a.mem_we); else n_pass++;
        tick();
        n_chk++; if (a_error !== 1'b1 || a_done !== 1'b0) $display("FAIL ovf sticky error/done: got %0h/%0h want 1/0", a_error, a_done); else n_pass++;
        n_chk++; if (a_word_count !== 9'd0) $display("FAIL ovf word_count: got %0d want 0", a_word_count); else n_pass++;
    endtask

    task automatic test_ready_toggle;
        logic [15:0] w [6] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060};
        logic [15:0] exp_sum;
        int k;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        exp_sum = 16'h0150;
`else
        exp_sum = 16'h0000;
`endif
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus_a.src_valid = 1'b1; bus_a.src_data = w[i];
            bus_a.mem_ready = (i % 2 == 0);
            tick();
        end
        bus_a.src_valid = 1'b0;
        k = 0;
        while (!a_done && k < 40) begin
            bus_a.mem_ready = ~bus_a.mem_ready;
            tick();
            k++;
        end
        n_chk++; if (a_done !== 1'b1) $display("FAIL toggle done: got %0h want 1 after %0d cycles", a_done, k); else n_pass++;
        n_chk++; if (a_error !== 1'b0) $display("FAIL toggle error: got %0h want 0", a_error); else n_pass++;
        n_chk++; if (a_word_count !== 9'd6) $display("FAIL toggle word_count: got %0d want 6", a_word_count); else n_pass++;
        n_chk++; if (a_checksum !== exp_sum) $display("FAIL toggle checksum: got %0h want %0h", a_checksum, exp_sum); else n_pass++;
        n_chk++; if (log_a_addr.size() !== 6) $display("FAIL toggle writes: got %0d want 6", log_a_addr.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            logic [7:0]  ga;
            logic [15:0] gd;
            ga = (i < log_a_addr.size()) ? log_a_addr[i] : 8'hxx;
            gd = (i < log_a_data.size()) ? log_a_data[i] : 16'hxxxx;
            n_chk++; if (ga !== 8'(i) || gd !== w[i])
                $display("FAIL toggle write%0d: got %0h@%0h want %0h@%0h", i, gd, ga, w[i], i);
            else n_pass++;
        end
    endtask

    task automatic test_addr_limit;
        do_reset();
        bus_b.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_b.src_valid = 1'b1; bus_b.src_data = 16'hB000 + 16'(i);
            tick();
        end
        bus_b.src_valid = 1'b0;
        n_chk++; if (bus_b.mem_we !== 1'b0) $display("FAIL addr_limit mem_we at end: got %0h want 0", bus_b.mem_we); else n_pass++;
        n_chk++; if (b_error !== 1'b0) $display("FAIL addr_limit early error: got %0h want 0", b_error); else n_pass++;
        tick();
        n_chk++; if (b_error !== 1'b1) $display("FAIL addr_limit error: got %0h want 1", b_error); else n_pass++;
        n_chk++; if (b_done !== 1'b0 || b_cpu_rst_b !== 1'b0) $display("FAIL addr_limit done/cpu_rst_b: got %0h/%0h want 0/0", b_done, b_cpu_rst_b); else n_pass++;
        n_chk++; if (b_word_count !== 3'd4) $display("FAIL addr_limit word_count: got %0d want 4", b_word_count); else n_pass++;
        n_chk++; if (log_b_addr.size() !== 4) $display("FAIL addr_limit writes: got %0d want 4", log_b_addr.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  ga;
            logic [15:0] gd;
            ga = (i < log_b_addr.size()) ? log_b_addr[i] : 2'bxx;
            gd = (i < log_b_data.size()) ? log_b_data[i] : 16'hxxxx;
            n_chk++; if (ga !== 2'(i) || gd !== 16'hB000 + 16'(i))
                $display("FAIL addr_limit write%0d: got %0h@%0h want %0h@%0h", i, gd, ga, 16'hB000 + 16'(i), i);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midload;
        logic [15:0] exp_sum;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        exp_sum = 16'hAAAA;
`else
        exp_sum = 16'h0000;
`endif
        do_reset();
        bus_a.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_a.src_valid = 1'b1; bus_a.src_data = 16'h5000 + 16'(i);
            tick();
        end
        n_chk++; if (a_word_count !== 9'd2) $display("FAIL midload word_count before reset: got %0d want 2", a_word_count); else n_pass++;
        bus_a.src_data = 16'h5003;
        #1 rst_b = 1'b0;
        #1;
        n_chk++; if (a_word_count !== 9'd0 || bus_a.mem_addr !== 8'h00) $display("FAIL midload async reset count/addr: got %0d/%0h want 0/0", a_word_count, bus_a.mem_addr); else n_pass++;
        n_chk++; if (bus_a.mem_we !== 1'b0 || a_done !== 1'b0) $display("FAIL midload async reset we/done: got %0h/%0h want 0/0", bus_a.mem_we, a_done); else n_pass++;
        bus_a.src_valid = 1'b0;
        repeat (2) tick();
        rst_b = 1'b1;
        tick();
        log_a_addr.delete(); log_a_data.delete();
        bus_a.src_valid = 1'b1; bus_a.src_data = 16'hAAAA;
        tick();
        bus_a.src_valid = 1'b0;
        repeat (2) tick();
        n_chk++; if (a_done !== 1'b1 || a_cpu_rst_b !== 1'b1) $display("FAIL midload reload done/cpu_rst_b: got %0h/%0h want 1/1", a_done, a_cpu_rst_b); else n_pass++;
        n_chk++; if (a_word_count !== 9'd1) $display("FAIL midload reload word_count: got %0d want 1", a_word_count); else n_pass++;
        n_chk++; if (a_checksum !== exp_sum) $display("FAIL midload checksum: got %0h want %0h", a_checksum, exp_sum); else n_pass++;
        n_chk++; if (log_a_addr.size() !== 1 || log_a_addr[0] !== 8'h00 || log_a_data[0] !== 16'hAAAA)
            $display("FAIL midload reload write: got %0d writes, first %0h@%0h want AAAA@0", log_a_addr.size(),
                     (log_a_data.size() > 0) ? log_a_data[0] : 16'hxxxx, (log_a_addr.size() > 0) ? log_a_addr[0] : 8'hxx);
        else n_pass++;
    endtask

    task automatic test_after_done;
        logic [15:0] exp_sum;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        exp_sum = 16'hAAAA;
`else
        exp_sum = 16'h0000;
`endif
        log_a_addr.delete(); log_a_data.delete();
        bus_a.src_valid = 1'b1; bus_a.src_data = 16'hFFFF;
        tick();
        n_chk++; if (bus_a.mem_we !== 1'b0) $display("FAIL after_done mem_we: got %0h want 0", bus_a.mem_we); else n_pass++;
        bus_a.src_valid = 1'b0;
        repeat (2) tick();
        n_chk++; if (a_word_count !== 9'd1) $display("FAIL after_done word_count: got %0d want 1", a_word_count); else n_pass++;
        n_chk++; if (a_checksum !== exp_sum) $display("FAIL after_done checksum: got %0h want %0h", a_checksum, exp_sum); else n_pass++;
        n_chk++; if (log_a_addr.size() !== 0) $display("FAIL after_done writes: got %0d want 0", log_a_addr.size()); else n_pass++;
        n_chk++; if (a_done !== 1'b1 || a_error !== 1'b0) $display("FAIL after_done done/error: got %0h/%0h want 1/0", a_done, a_error); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream3();
        test_fifo_overflow();
        test_ready_toggle();
        test_addr_limit();
        test_reset_midload();
        test_after_done();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
